// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode constants, FSM state encodings
// and small decode helpers. Imported by alu_pipe and alu_pipe_mul.
package alu_pkg;

  // 6-bit operator encoding, kept compatible with the combinational ALU
  localparam logic [5:0] ALU_ADD = 6'b011000;
  localparam logic [5:0] ALU_SUB = 6'b011001;
  localparam logic [5:0] ALU_XOR = 6'b101111;
  localparam logic [5:0] ALU_OR  = 6'b101110;
  localparam logic [5:0] ALU_AND = 6'b010101;
  localparam logic [5:0] ALU_SRA = 6'b100100;
  localparam logic [5:0] ALU_SRL = 6'b100101;
  localparam logic [5:0] ALU_SLL = 6'b100111;
  localparam logic [5:0] ALU_LTS = 6'b000000;
  localparam logic [5:0] ALU_LTU = 6'b000001;
  localparam logic [5:0] ALU_GES = 6'b001010;
  localparam logic [5:0] ALU_GEU = 6'b001011;
  localparam logic [5:0] ALU_EQ  = 6'b001100;
  localparam logic [5:0] ALU_NE  = 6'b001101;
  localparam logic [5:0] ALU_MUL = 6'b110000;

  // Control FSM states
  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StMul  = 1'b1;

  // True for the six compare operators
  function automatic logic is_cmp_op(input logic [5:0] op);
    logic res;
    res = 1'b0;
    case (op)
      ALU_LTS, ALU_LTU, ALU_GES, ALU_GEU, ALU_EQ, ALU_NE: res = 1'b1;
      default:                                           res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_pipe_mul.sv
// Iterative shift-add multiplier for alu_pipe: one multiplier bit per cycle.
// start_i captures operands; after WIDTH iterations done_o rises and holds the
// low WIDTH bits of A*B on product_o until ack_i retires the operation.
// Only instantiated when ALU_PIPE_MUL_EN is defined.
module alu_pipe_mul
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             ack_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic             busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             last_iter_done;

  assign last_iter_done = (cnt_q == CW'(WIDTH));
  assign done_o         = busy_q & last_iter_done;
  assign product_o      = acc_q;

  // Next-state: load on start, add-and-shift until all multiplier bits consumed
  always_comb begin
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    acc_d   = acc_q;
    if (start_i) begin
      busy_d  = 1'b1;
      cnt_d   = '0;
      mcand_d = operand_a_i;
      mplr_d  = operand_b_i;
      acc_d   = '0;
    end else if (busy_q && !last_iter_done) begin
      if (mplr_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d = mcand_q << 1;
      mplr_d  = mplr_q >> 1;
      cnt_d   = cnt_q + CW'(1);
    end else if (done_o && ack_i) begin
      busy_d = 1'b0;
    end
  end

  // Multiplier state registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      acc_q   <= '0;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake on request and result sides.
// One operation in flight; single-cycle ops have latency 1 and full throughput.
// Optional feature: define ALU_PIPE_MUL_EN to add the iterative ALU_MUL operation
// (result WIDTH+1 cycles after accept); otherwise ALU_MUL decodes as illegal.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [5:0]       operator_i,
  input  logic [WIDTH-1:0] operand_a_i,
  input  logic [WIDTH-1:0] operand_b_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             comparison_result_o,
  output logic             illegal_op_o
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cmp_q, cmp_d;
  logic             illegal_q, illegal_d;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cmp;
  logic             alu_illegal;
  logic             mul_op;
  logic             is_idle;
  logic             out_free;
  logic             accept;

  assign shamt    = operand_b_i[SHW-1:0];
  // Output slot can take a new result when empty or being drained this edge
  assign out_free = ~valid_q | ready_i;
  // Gated by reset so the block never advertises ready while held in reset
  assign ready_o  = is_idle & out_free & rst_n_i;
  assign accept   = valid_i & ready_o;

`ifdef ALU_PIPE_MUL_EN
  logic [0:0]       state_q, state_d;
  logic             mul_start, mul_ack, mul_done;
  logic [WIDTH-1:0] mul_product;

  assign is_idle = (state_q == StIdle);

  alu_pipe_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .start_i     (mul_start),
    .ack_i       (mul_ack),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .done_o      (mul_done),
    .product_o   (mul_product)
  );
`else
  assign is_idle = 1'b1;
`endif

  // Combinational datapath for all single-cycle operators
  always_comb begin
    alu_res     = '0;
    alu_cmp     = 1'b0;
    alu_illegal = 1'b0;
    mul_op      = 1'b0;
    case (operator_i)
      ALU_ADD: alu_res = operand_a_i + operand_b_i;
      ALU_SUB: alu_res = operand_a_i - operand_b_i;
      ALU_XOR: alu_res = operand_a_i ^ operand_b_i;
      ALU_OR:  alu_res = operand_a_i | operand_b_i;
      ALU_AND: alu_res = operand_a_i & operand_b_i;
      ALU_SLL: alu_res = operand_a_i << shamt;
      ALU_SRL: alu_res = operand_a_i >> shamt;
      ALU_SRA: alu_res = $signed(operand_a_i) >>> shamt;
      ALU_LTS: alu_cmp = $signed(operand_a_i) < $signed(operand_b_i);
      ALU_LTU: alu_cmp = operand_a_i < operand_b_i;
      ALU_GES: alu_cmp = $signed(operand_a_i) >= $signed(operand_b_i);
      ALU_GEU: alu_cmp = operand_a_i >= operand_b_i;
      ALU_EQ:  alu_cmp = operand_a_i == operand_b_i;
      ALU_NE:  alu_cmp = operand_a_i != operand_b_i;
`ifdef ALU_PIPE_MUL_EN
      ALU_MUL: mul_op = 1'b1;
`endif
      default: alu_illegal = 1'b1;
    endcase
    // Compare results are zero-extended into the result word
    if (is_cmp_op(operator_i)) begin
      alu_res = {{(WIDTH - 1){1'b0}}, alu_cmp};
    end
  end

  // Handshake, output register and FSM next-state
  always_comb begin
    valid_d   = valid_q;
    result_d  = result_q;
    cmp_d     = cmp_q;
    illegal_d = illegal_q;
`ifdef ALU_PIPE_MUL_EN
    state_d   = state_q;
    mul_start = 1'b0;
    mul_ack   = 1'b0;
`endif
    if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    if (accept && !mul_op) begin
      valid_d   = 1'b1;
      result_d  = alu_res;
      cmp_d     = alu_cmp;
      illegal_d = alu_illegal;
    end
`ifdef ALU_PIPE_MUL_EN
    if (accept && mul_op) begin
      state_d   = StMul;
      mul_start = 1'b1;
    end
    // Final product waits in the multiplier until the output slot frees up
    if (state_q == StMul && mul_done && out_free) begin
      valid_d   = 1'b1;
      result_d  = mul_product;
      cmp_d     = 1'b0;
      illegal_d = 1'b0;
      mul_ack   = 1'b1;
      state_d   = StIdle;
    end
`endif
  end

  // Output and control registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q   <= 1'b0;
      result_q  <= '0;
      cmp_q     <= 1'b0;
      illegal_q <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
      state_q   <= StIdle;
`endif
    end else begin
      valid_q   <= valid_d;
      result_q  <= result_d;
      cmp_q     <= cmp_d;
      illegal_q <= illegal_d;
`ifdef ALU_PIPE_MUL_EN
      state_q   <= state_d;
`endif
    end
  end

  assign valid_o             = valid_q;
  assign result_o            = result_q;
  assign comparison_result_o = cmp_q;
  assign illegal_op_o        = illegal_q;

endmodule
